// File: rtl/ttt_pkg.sv
// ============================================================================
// Module : ttt_pkg
// Brief  : Shared encodings for the tic-tac-toe board controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Bit n of a mask is cell n, row-major from the top-left corner.
  localparam logic [8:0] LINE_ROW0  = 9'h007;
  localparam logic [8:0] LINE_ROW1  = 9'h038;
  localparam logic [8:0] LINE_ROW2  = 9'h1C0;
  localparam logic [8:0] LINE_COL0  = 9'h049;
  localparam logic [8:0] LINE_COL1  = 9'h092;
  localparam logic [8:0] LINE_COL2  = 9'h124;
  localparam logic [8:0] LINE_DIAG0 = 9'h111;
  localparam logic [8:0] LINE_DIAG1 = 9'h054;

  localparam int NUM_LINES = 8;

  localparam logic [NUM_LINES-1:0][8:0] LINE_MASKS = {
    LINE_DIAG1, LINE_DIAG0, LINE_COL2, LINE_COL1,
    LINE_COL0,  LINE_ROW2,  LINE_ROW1, LINE_ROW0
  };

  localparam int BLINK_PERIOD = 16;

endpackage

`default_nettype wire

// File: rtl/line_check.sv
// ============================================================================
// Module : line_check
// Brief  : Combinational detector: union of all complete lines in a mask.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_check
  import ttt_pkg::*;
(
  input  logic [8:0] i_mask,
  output logic [8:0] o_lines,
  output logic       o_any
);

  logic [NUM_LINES-1:0]      w_hit;
  logic [NUM_LINES-1:0][8:0] w_sel;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    assign w_hit[g] = ((i_mask & LINE_MASKS[g]) == LINE_MASKS[g]);
    assign w_sel[g] = w_hit[g] ? LINE_MASKS[g] : 9'h000;
  end

  always_comb begin
    o_lines = 9'h000;
    for (int i = 0; i < NUM_LINES; i++) begin
      o_lines = o_lines | w_sel[i];
    end
  end

  assign o_any = |w_hit;

endmodule

`default_nettype wire

// File: rtl/board_ctrl.sv
// ============================================================================
// Module : board_ctrl
// Brief  : Tic-tac-toe board state, move legality, win/draw detection.
//          Optional winning-line blink enabled by BOARD_CTRL_BLINK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_ctrl
  import ttt_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [3:0] move_idx,
  output logic       move_ready,
  input  logic       new_game,
  input  logic       frame_tick,
  output logic [8:0] x_mask,
  output logic [8:0] o_mask,
  output logic [8:0] hl_mask,
  output logic       turn_o,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       illegal
);

  state_t     r_state, w_state_nxt;
  logic [8:0] r_x, w_x_nxt;
  logic [8:0] r_o, w_o_nxt;
  logic [8:0] r_hl, w_hl_nxt;
  logic       r_turn, w_turn_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic       r_over, w_over_nxt;
  logic       r_illegal, w_illegal_nxt;

  logic [8:0] w_cell;
  logic       w_legal;
  logic [8:0] w_mover;
  logic [8:0] w_lines;
  logic       w_any;

  // A shift past bit 8 yields zero, so out-of-range indices need the explicit bound.
  assign w_cell  = 9'h001 << move_idx;
  assign w_legal = (move_idx <= 4'd8) && ((w_cell & (r_x | r_o)) == 9'h000);
  assign w_mover = r_turn ? r_o : r_x;

  line_check u_line_check (
    .i_mask  (w_mover),
    .o_lines (w_lines),
    .o_any   (w_any)
  );

`ifdef BOARD_CTRL_BLINK_EN
  localparam logic [4:0] c_blink_period = 5'(BLINK_PERIOD);
  logic [4:0] r_cnt, w_cnt_nxt;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= ST_PLAY;
      r_x       <= 9'h000;
      r_o       <= 9'h000;
      r_hl      <= 9'h000;
      r_turn    <= 1'b0;
      r_winner  <= WIN_NONE;
      r_over    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef BOARD_CTRL_BLINK_EN
      r_cnt     <= 5'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_o       <= w_o_nxt;
      r_hl      <= w_hl_nxt;
      r_turn    <= w_turn_nxt;
      r_winner  <= w_winner_nxt;
      r_over    <= w_over_nxt;
      r_illegal <= w_illegal_nxt;
`ifdef BOARD_CTRL_BLINK_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_o_nxt       = r_o;
    w_hl_nxt      = r_hl;
    w_turn_nxt    = r_turn;
    w_winner_nxt  = r_winner;
    w_over_nxt    = r_over;
    w_illegal_nxt = 1'b0;
`ifdef BOARD_CTRL_BLINK_EN
    w_cnt_nxt     = r_cnt;
`endif
    if (new_game) begin
      w_state_nxt  = ST_PLAY;
      w_x_nxt      = 9'h000;
      w_o_nxt      = 9'h000;
      w_hl_nxt     = 9'h000;
      w_turn_nxt   = 1'b0;
      w_winner_nxt = WIN_NONE;
      w_over_nxt   = 1'b0;
`ifdef BOARD_CTRL_BLINK_EN
      w_cnt_nxt    = 5'd0;
`endif
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (move_valid) begin
            if (w_legal) begin
              if (r_turn) w_o_nxt = r_o | w_cell;
              else        w_x_nxt = r_x | w_cell;
              w_state_nxt = ST_CHECK;
            end else begin
              w_illegal_nxt = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (w_any) begin
            w_winner_nxt = r_turn ? WIN_O : WIN_X;
            w_over_nxt   = 1'b1;
            w_hl_nxt     = w_lines;
            w_state_nxt  = ST_DONE;
          end else if (&(r_x | r_o)) begin
            w_winner_nxt = WIN_DRAW;
            w_over_nxt   = 1'b1;
            w_state_nxt  = ST_DONE;
          end else begin
            w_turn_nxt  = ~r_turn;
            w_state_nxt = ST_PLAY;
          end
        end
        ST_DONE: begin
`ifdef BOARD_CTRL_BLINK_EN
          if (frame_tick && (r_winner != WIN_DRAW)) begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
`endif
        end
        default: w_state_nxt = ST_PLAY;
      endcase
    end
  end

  assign move_ready = (r_state == ST_PLAY);
  assign x_mask     = r_x;
  assign o_mask     = r_o;
  assign turn_o     = r_turn;
  assign winner     = r_winner;
  assign game_over  = r_over;
  assign illegal    = r_illegal;

`ifdef BOARD_CTRL_BLINK_EN
  // Phase is "on" for the first half of the 5-bit count, so it starts on after clear.
  assign hl_mask = (r_cnt < c_blink_period) ? r_hl : 9'h000;
`else
  logic w_unused_tick;
  assign w_unused_tick = frame_tick;
  assign hl_mask       = r_hl;
`endif

endmodule

`default_nettype wire

// File: tb/tb_board_ctrl.sv
// ============================================================================
// Module : tb_board_ctrl
// Brief  : Self-checking bench for board_ctrl: scripted games plus random play.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_ctrl;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       move_valid = 1'b0;
  logic [3:0] move_idx = 4'd0;
  logic       new_game = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_ready;
  logic [8:0] x_mask, o_mask, hl_mask;
  logic       turn_o, game_over, illegal;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 pclk = ~pclk;

  board_ctrl dut (
    .pclk       (pclk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_idx   (move_idx),
    .move_ready (move_ready),
    .new_game   (new_game),
    .frame_tick (frame_tick),
    .x_mask     (x_mask),
    .o_mask     (o_mask),
    .hl_mask    (hl_mask),
    .turn_o     (turn_o),
    .winner     (winner),
    .game_over  (game_over),
    .illegal    (illegal)
  );

  // Reference model: board as an array of owners (0 empty, 1 X, 2 O).
  int         m_board [9];
  bit         m_turn;
  bit  [1:0]  m_win;
  bit         m_over;
  logic [8:0] m_hl;
  bit         m_pend;
  bit         m_done;
  bit         m_ill;
  int         m_ticks;

  int tri_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_turn = 0; m_win = 0; m_over = 0; m_hl = '0;
    m_pend = 0; m_done = 0; m_ill = 0; m_ticks = 0;
  endtask

  task automatic model_step(input bit r, input bit ng, input bit mv,
                            input logic [3:0] idx, input bit ft);
    int p;
    int full;
    logic [8:0] lines;
    p = m_turn ? 2 : 1;
    if (r || ng) begin
      model_clear();
    end else if (m_pend) begin
      m_ill = 0;
      lines = '0;
      for (int l = 0; l < 8; l++)
        if (m_board[tri_tab[l][0]] == p && m_board[tri_tab[l][1]] == p &&
            m_board[tri_tab[l][2]] == p)
          lines = lines | (9'd1 << tri_tab[l][0]) | (9'd1 << tri_tab[l][1])
                        | (9'd1 << tri_tab[l][2]);
      full = 1;
      for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
      if (lines != 0) begin
        m_win = 2'(p); m_over = 1; m_hl = lines; m_done = 1;
      end else if (full == 1) begin
        m_win = 2'b11; m_over = 1; m_done = 1;
      end else begin
        m_turn = ~m_turn;
      end
      m_pend = 0;
    end else if (m_done) begin
      m_ill = 0;
`ifdef BOARD_CTRL_BLINK_EN
      if (ft && m_win != 2'b11) m_ticks = (m_ticks + 1) % 32;
`endif
    end else begin
      m_ill = 0;
      if (mv) begin
        if (idx <= 8 && m_board[idx] == 0) begin
          m_board[idx] = p;
          m_pend = 1;
        end else begin
          m_ill = 1;
        end
      end
    end
  endtask

  function automatic logic [8:0] cells_of(input int who);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) if (m_board[i] == who) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [8:0] exp_hl();
`ifdef BOARD_CTRL_BLINK_EN
    return (m_ticks < 16) ? m_hl : 9'h000;
`else
    return m_hl;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("x_mask",     32'(x_mask),     32'(cells_of(1)));
      chk("o_mask",     32'(o_mask),     32'(cells_of(2)));
      chk("hl_mask",    32'(hl_mask),    32'(exp_hl()));
      chk("turn_o",     32'(turn_o),     32'(m_turn));
      chk("winner",     32'(winner),     32'(m_win));
      chk("game_over",  32'(game_over),  32'(m_over));
      chk("illegal",    32'(illegal),    32'(m_ill));
      chk("move_ready", 32'(move_ready), 32'(!m_pend && !m_done));
    end
  end

  task automatic cycle();
    @(posedge pclk);
    model_step(rst, new_game, move_valid, move_idx, frame_tick);
    #1;
  endtask

  task automatic do_move(input int idx);
    move_valid = 1'b1;
    move_idx   = 4'(idx);
    cycle();
    move_valid = 1'b0;
    cycle();
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
  endtask

  initial begin
    model_clear();
    cycle();
    cycle();
    chk_en = 1'b1;
    rst = 1'b0;
    cycle();
    chk("reset_ready",  32'(move_ready), 32'd1);
    chk("reset_x",      32'(x_mask),     32'h0);
    chk("reset_winner", 32'(winner),     32'd0);
    chk("reset_hl",     32'(hl_mask),    32'h0);

    // Diagonal win for X
    do_move(0); do_move(1); do_move(4); do_move(2); do_move(8);
    chk("win_winner", 32'(winner),     32'd1);
    chk("win_hl",     32'(hl_mask),    32'h111);
    chk("win_over",   32'(game_over),  32'd1);
    chk("win_ready",  32'(move_ready), 32'd0);

    move_valid = 1'b1; move_idx = 4'd5;
    cycle();
    move_valid = 1'b0;
    chk("done_no_illegal", 32'(illegal), 32'd0);
    chk("done_o_kept",     32'(o_mask),  32'h006);

`ifdef BOARD_CTRL_BLINK_EN
    for (int i = 0; i < 32; i++) begin
      chk("blink_phase", 32'(hl_mask), (i < 16) ? 32'h111 : 32'h0);
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
    end
    chk("blink_wrap_on", 32'(hl_mask), 32'h111);
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0;
    end
    chk("blink_off", 32'(hl_mask), 32'h0);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("blink_rst_hl", 32'(hl_mask), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0;
    end
    chk("steady_hl", 32'(hl_mask), 32'h111);
`endif

    pulse_new_game();
    cycle();
    chk("ng_x",     32'(x_mask),     32'h0);
    chk("ng_turn",  32'(turn_o),     32'd0);
    chk("ng_ready", 32'(move_ready), 32'd1);

    // Occupied cell and out-of-range index
    do_move(4);
    move_valid = 1'b1; move_idx = 4'd4;
    cycle();
    chk("occ_illegal", 32'(illegal), 32'd1);
    chk("occ_x",       32'(x_mask),  32'h010);
    chk("occ_o",       32'(o_mask),  32'h0);
    chk("occ_turn",    32'(turn_o),  32'd1);
    move_valid = 1'b0;
    cycle();
    chk("occ_pulse_end", 32'(illegal), 32'd0);
    move_valid = 1'b1; move_idx = 4'd9;
    cycle();
    move_valid = 1'b0;
    chk("idx9_illegal", 32'(illegal),    32'd1);
    chk("idx9_x",       32'(x_mask),     32'h010);
    chk("idx9_ready",   32'(move_ready), 32'd1);
    cycle();
    chk("idx9_pulse_end", 32'(illegal), 32'd0);

    // Draw: X = {0,2,3,7,8}, O = {1,4,5,6}
    pulse_new_game();
    do_move(0); do_move(1); do_move(2); do_move(4); do_move(3);
    do_move(5); do_move(7); do_move(6); do_move(8);
    chk("draw_winner", 32'(winner),    32'd3);
    chk("draw_hl",     32'(hl_mask),   32'h0);
    chk("draw_over",   32'(game_over), 32'd1);

    // new_game wins against a simultaneous move
    pulse_new_game();
    new_game = 1'b1; move_valid = 1'b1; move_idx = 4'd0;
    cycle();
    new_game = 1'b0; move_valid = 1'b0;
    chk("ngmv_x",     32'(x_mask),     32'h0);
    chk("ngmv_turn",  32'(turn_o),     32'd0);
    chk("ngmv_ready", 32'(move_ready), 32'd1);

    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      new_game   = ($urandom_range(0, 49) == 0);
      move_valid = ($urandom_range(0, 9) < 6);
      move_idx   = 4'($urandom_range(0, 10));
      frame_tick = ($urandom_range(0, 4) == 0);
      cycle();
    end
    rst = 1'b0; new_game = 1'b0; move_valid = 1'b0; frame_tick = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
